// File: rtl/rx_decoder_10b8b.sv
// 10b/8b receive decoder: Clause 36 code-group lookup, running-disparity tracking,
// code/disparity error flags and a saturating error counter. One-cycle registered latency.
module rx_decoder_10b8b #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [9:0]       rx_code_group,
  input  logic             code_status,
  input  logic             clr_count,
  output logic [7:0]       rxd,
  output logic             rx_is_k,
  output logic             rx_valid,
  output logic             code_err,
  output logic             disp_err,
  output logic             rd_out,
  output logic [CNT_W-1:0] err_count
);

  logic [5:0]       w_6b;
  logic [3:0]       w_4b;
  logic [3:0]       w_k4;
  logic [2:0]       w_ones6;
  logic [2:0]       w_ones4;
  logic [4:0]       w_x;
  logic [2:0]       w_dy;
  logic [2:0]       w_ky;
  logic [2:0]       w_y;
  logic             w_ok6;
  logic             w_ok4;
  logic             w_kok4;
  logic             w_alt4;
  logic             w_k28;
  logic             w_k7;
  logic             w_alt_p;
  logic             w_alt_n;
  logic             w_alt_ok;
  logic             w_code_err;
  logic             w_disp_err;
  logic             w_is_k;
  logic             w_rd6;
  logic             w_rd4;
  logic             w_derr6;
  logic             w_derr4;
  logic             w_cnt_inc;

  logic [7:0]       r_rxd;
  logic             r_is_k;
  logic             r_valid;
  logic             r_code_err;
  logic             r_disp_err;
  logic             r_rd;
  logic [CNT_W-1:0] r_cnt;

  assign w_6b = rx_code_group[9:4];
  assign w_4b = rx_code_group[3:0];

  always_comb begin
    w_ones6 = '0;
    for (int i = 0; i < 6; i++) w_ones6 = w_ones6 + {2'b00, w_6b[i]};
    w_ones4 = '0;
    for (int i = 0; i < 4; i++) w_ones4 = w_ones4 + {2'b00, w_4b[i]};
  end

  // 6b -> EDCBA, both RD columns; flags mark K28 and the sub-blocks that permit A7/K.x.7.
  always_comb begin
    w_x     = 5'd0;
    w_ok6   = 1'b1;
    w_k28   = 1'b0;
    w_k7    = 1'b0;
    w_alt_p = 1'b0;
    w_alt_n = 1'b0;
    case (w_6b)
      6'b100111, 6'b011000: w_x = 5'd0;
      6'b011101, 6'b100010: w_x = 5'd1;
      6'b101101, 6'b010010: w_x = 5'd2;
      6'b110001:            w_x = 5'd3;
      6'b110101, 6'b001010: w_x = 5'd4;
      6'b101001:            w_x = 5'd5;
      6'b011001:            w_x = 5'd6;
      6'b111000, 6'b000111: w_x = 5'd7;
      6'b111001, 6'b000110: w_x = 5'd8;
      6'b100101:            w_x = 5'd9;
      6'b010101:            w_x = 5'd10;
      6'b110100:            begin w_x = 5'd11; w_alt_n = 1'b1; end
      6'b001101:            w_x = 5'd12;
      6'b101100:            begin w_x = 5'd13; w_alt_n = 1'b1; end
      6'b011100:            begin w_x = 5'd14; w_alt_n = 1'b1; end
      6'b010111, 6'b101000: w_x = 5'd15;
      6'b011011, 6'b100100: w_x = 5'd16;
      6'b100011:            begin w_x = 5'd17; w_alt_p = 1'b1; end
      6'b010011:            begin w_x = 5'd18; w_alt_p = 1'b1; end
      6'b110010:            w_x = 5'd19;
      6'b001011:            begin w_x = 5'd20; w_alt_p = 1'b1; end
      6'b101010:            w_x = 5'd21;
      6'b011010:            w_x = 5'd22;
      6'b111010, 6'b000101: begin w_x = 5'd23; w_k7 = 1'b1; end
      6'b110011, 6'b001100: w_x = 5'd24;
      6'b100110:            w_x = 5'd25;
      6'b010110:            w_x = 5'd26;
      6'b110110, 6'b001001: begin w_x = 5'd27; w_k7 = 1'b1; end
      6'b001110:            w_x = 5'd28;
      6'b101110, 6'b010001: begin w_x = 5'd29; w_k7 = 1'b1; end
      6'b011110, 6'b100001: begin w_x = 5'd30; w_k7 = 1'b1; end
      6'b101011, 6'b010100: w_x = 5'd31;
      6'b001111, 6'b110000: begin w_x = 5'd28; w_k28 = 1'b1; end
      default:              w_ok6 = 1'b0;
    endcase
  end

  // Data 4b -> HGF
  always_comb begin
    w_dy   = 3'd0;
    w_ok4  = 1'b1;
    w_alt4 = 1'b0;
    case (w_4b)
      4'b1011, 4'b0100: w_dy = 3'd0;
      4'b1001:          w_dy = 3'd1;
      4'b0101:          w_dy = 3'd2;
      4'b1100, 4'b0011: w_dy = 3'd3;
      4'b1101, 4'b0010: w_dy = 3'd4;
      4'b1010:          w_dy = 3'd5;
      4'b0110:          w_dy = 3'd6;
      4'b1110, 4'b0001: w_dy = 3'd7;
      4'b0111, 4'b1000: begin w_dy = 3'd7; w_alt4 = 1'b1; end
      default:          w_ok4 = 1'b0;
    endcase
  end

  // K28 4b follows the complemented column after 110000, so fold it onto the 001111 set.
  assign w_k4 = (w_6b == 6'b110000) ? ~w_4b : w_4b;

  always_comb begin
    w_ky   = 3'd0;
    w_kok4 = 1'b1;
    case (w_k4)
      4'b0100: w_ky = 3'd0;
      4'b1001: w_ky = 3'd1;
      4'b0101: w_ky = 3'd2;
      4'b0011: w_ky = 3'd3;
      4'b0010: w_ky = 3'd4;
      4'b1010: w_ky = 3'd5;
      4'b0110: w_ky = 3'd6;
      4'b1000: w_ky = 3'd7;
      default: w_kok4 = 1'b0;
    endcase
  end

  assign w_alt_ok   = w_k7 || (w_4b == 4'b0111 && w_alt_p) || (w_4b == 4'b1000 && w_alt_n);
  assign w_code_err = !w_ok6 || (w_k28 ? !w_kok4 : (!w_ok4 || (w_alt4 && !w_alt_ok)));
  assign w_is_k     = !w_code_err && (w_k28 || (w_k7 && w_alt4));
  assign w_y        = w_k28 ? w_ky : w_dy;

  always_comb begin
    if (w_ones6 > 3'd3)          w_rd6 = 1'b1;
    else if (w_ones6 < 3'd3)     w_rd6 = 1'b0;
    else if (w_6b == 6'b000111)  w_rd6 = 1'b1;
    else if (w_6b == 6'b111000)  w_rd6 = 1'b0;
    else                         w_rd6 = r_rd;
    if (w_ones4 > 3'd2)          w_rd4 = 1'b1;
    else if (w_ones4 < 3'd2)     w_rd4 = 1'b0;
    else if (w_4b == 4'b0011)    w_rd4 = 1'b1;
    else if (w_4b == 4'b1100)    w_rd4 = 1'b0;
    else                         w_rd4 = w_rd6;
  end

  assign w_derr6    = (w_ones6 == 3'd4 && r_rd) || (w_ones6 == 3'd2 && !r_rd);
  assign w_derr4    = (w_ones4 == 3'd3 && w_rd6) || (w_ones4 == 3'd1 && !w_rd6);
  assign w_disp_err = !w_code_err && (w_derr6 || w_derr4);
  assign w_cnt_inc  = code_status && (w_code_err || w_disp_err) && (r_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_rxd      <= 8'h00;
      r_is_k     <= 1'b0;
      r_valid    <= 1'b0;
      r_code_err <= 1'b0;
      r_disp_err <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rxd      <= w_code_err ? 8'h00 : {w_y, w_x};
      r_is_k     <= w_is_k;
      r_valid    <= code_status;
      r_code_err <= code_status && w_code_err;
      r_disp_err <= code_status && w_disp_err;
      r_rd       <= w_rd4;
      if (clr_count)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rxd       = r_rxd;
  assign rx_is_k   = r_is_k;
  assign rx_valid  = r_valid;
  assign code_err  = r_code_err;
  assign disp_err  = r_disp_err;
  assign rd_out    = r_rd;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_rx_decoder_10b8b.sv
// Bench for rx_decoder_10b8b: hand-computed vector table plus saturation sequences,
// checked through an expected-result queue one cycle after each word is driven.
module tb_rx_decoder_10b8b;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] rx_code_group = '0;
  logic       code_status = 1'b0;
  logic       clr_count = 1'b0;

  logic [7:0] rxd, rxd4;
  logic       rx_is_k, rx_valid, code_err, disp_err, rd_out;
  logic       rx_is_k4, rx_valid4, code_err4, disp_err4, rd_out4;
  logic [7:0] err_count;
  logic [3:0] err_count4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0] code;
    logic       st, clr, rst;
    logic [7:0] rxd;
    logic       k, v, ce, de, rd, cd;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] rxd;
    logic       k, v, ce, de, rd, cd;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   m_cnt8 = 0;
  int   m_cnt4 = 0;
  int   n_step = 0;

  always #5 clk = ~clk;

  rx_decoder_10b8b u_dut (
    .clk(clk), .RESET(RESET), .rx_code_group(rx_code_group), .code_status(code_status),
    .clr_count(clr_count), .rxd(rxd), .rx_is_k(rx_is_k), .rx_valid(rx_valid),
    .code_err(code_err), .disp_err(disp_err), .rd_out(rd_out), .err_count(err_count)
  );

  rx_decoder_10b8b #(.CNT_W(4)) u_dut4 (
    .clk(clk), .RESET(RESET), .rx_code_group(rx_code_group), .code_status(code_status),
    .clr_count(clr_count), .rxd(rxd4), .rx_is_k(rx_is_k4), .rx_valid(rx_valid4),
    .code_err(code_err4), .disp_err(disp_err4), .rd_out(rd_out4), .err_count(err_count4)
  );

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s [word %0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] code, input logic st, clr, rst, input logic [7:0] e_rxd,
                     input logic k, v, ce, de, rd, cd);
    vec_t r;
    r.code = code; r.st = st; r.clr = clr; r.rst = rst;
    r.rxd = e_rxd; r.k = k; r.v = v; r.ce = ce; r.de = de; r.rd = rd; r.cd = cd;
    vecs.push_back(r);
  endtask

  task automatic step(input vec_t r);
    exp_t e;
    @(negedge clk);
    rx_code_group = r.code;
    code_status   = r.st;
    clr_count     = r.clr;
    RESET         = r.rst;
    if (r.rst || r.clr) begin
      m_cnt8 = 0;
      m_cnt4 = 0;
    end else if (r.v && (r.ce || r.de)) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt4 < 15)  m_cnt4++;
    end
    e.idx = n_step; e.rxd = r.rxd; e.k = r.k; e.v = r.v; e.ce = r.ce; e.de = r.de;
    e.rd = r.rd; e.cd = r.cd; e.cnt8 = 8'(m_cnt8); e.cnt4 = 4'(m_cnt4);
    sb.push_back(e);
    n_step++;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.cd) begin
        check("rxd", e.idx, rxd, e.rxd);
        check("rx_is_k", e.idx, rx_is_k, e.k);
      end
      check("rx_valid", e.idx, rx_valid, e.v);
      check("code_err", e.idx, code_err, e.ce);
      check("disp_err", e.idx, disp_err, e.de);
      check("rd_out", e.idx, rd_out, e.rd);
      check("err_count", e.idx, err_count, e.cnt8);
      check("err_count_w4", e.idx, err_count4, e.cnt4);
    end
  end

  initial begin
    vec_t bad;
    vec_t bad_clr;
    vec_t rst_v;
    //  code            st clr rst rxd   k  v  ce de rd cd
    add(10'b0000000000, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1);
    add(10'b0011111010, 1, 0, 0, 8'hBC, 1, 1, 0, 0, 1, 1); // K28.5 RD-
    add(10'b1001000101, 1, 0, 0, 8'h50, 0, 1, 0, 0, 0, 1); // D16.2 RD+
    add(10'b1010010110, 1, 0, 0, 8'hC5, 0, 1, 0, 0, 0, 1); // D5.6
    add(10'b1001110100, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1); // D0.0 RD-
    add(10'b1010101010, 1, 0, 0, 8'hB5, 0, 1, 0, 0, 0, 1); // D21.5
    add(10'b1100011100, 1, 0, 0, 8'h63, 0, 1, 0, 0, 0, 1); // D3.3 RD-
    add(10'b1110001011, 1, 0, 0, 8'h07, 0, 1, 0, 0, 1, 1); // D7.0 RD-
    add(10'b1100000101, 1, 0, 0, 8'hBC, 1, 1, 0, 0, 0, 1); // K28.5 RD+
    add(10'b1000110111, 1, 0, 0, 8'hF1, 0, 1, 0, 0, 1, 1); // D17.A7 RD-
    add(10'b1101001000, 1, 0, 0, 8'hEB, 0, 1, 0, 0, 0, 1); // D11.A7 RD+
    add(10'b1110101000, 1, 0, 0, 8'hF7, 1, 1, 0, 0, 0, 1); // K23.7 RD-
    add(10'b0011111000, 1, 0, 0, 8'hFC, 1, 1, 0, 0, 0, 1); // K28.7 RD-
    add(10'b0011110100, 1, 0, 0, 8'h1C, 1, 1, 0, 0, 0, 1); // K28.0 RD-
    add(10'b1010110001, 1, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 1); // D31.7 RD-
    add(10'b0110001011, 1, 0, 0, 8'h00, 0, 1, 0, 1, 1, 1); // D0.0 RD+ form under RD-
    add(10'b0000011111, 1, 0, 0, 8'h00, 0, 1, 1, 0, 1, 1); // bad 6b and 4b
    add(10'b1010010111, 1, 0, 0, 8'h00, 0, 1, 1, 0, 1, 1); // alternate 7 after D5
    add(10'b1100000011, 1, 0, 0, 8'h00, 0, 1, 1, 0, 1, 1); // K28 with non-K28 4b
    add(10'b0000011111, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0); // unlocked, invalid
    add(10'b1100000101, 0, 0, 0, 8'hBC, 1, 0, 0, 0, 0, 1); // unlocked, K28.5 RD+
    add(10'b1010101010, 1, 1, 0, 8'hB5, 0, 1, 0, 0, 0, 1); // clear
    add(10'b1010010100, 1, 0, 0, 8'h05, 0, 1, 0, 1, 0, 1); // 4b disparity error
    add(10'b0000011111, 1, 1, 0, 8'h00, 0, 1, 1, 0, 1, 1); // clear beats increment
    add(10'b0011111010, 1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1); // reset while RD+
    add(10'b0011111010, 1, 0, 0, 8'hBC, 1, 1, 0, 0, 1, 1); // decoded against RD-
    add(10'b0000000000, 1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1);
    add(10'b1001000101, 1, 0, 0, 8'h50, 0, 1, 0, 1, 0, 1); // D16.2 RD+ under RD-

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    bad     = '{code: 10'b0000011111, st: 1, clr: 0, rst: 0, rxd: 8'h00,
                k: 0, v: 1, ce: 1, de: 0, rd: 1, cd: 1};
    bad_clr = bad;
    bad_clr.clr = 1'b1;
    rst_v   = '{code: 10'b0, st: 0, clr: 0, rst: 1, rxd: 8'h00,
                k: 0, v: 0, ce: 0, de: 0, rd: 0, cd: 1};

    // Narrow counter saturates at 15 after 20 errors; clear with an errored word.
    step(rst_v);
    for (int i = 0; i < 20; i++) step(bad);
    step(bad_clr);
    // Both counters to saturation, then clear.
    for (int i = 0; i < 260; i++) step(bad);
    step(bad_clr);
    step(bad);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", n_step, sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
